// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x-oversampled UART receiver that deserialises 5-8 bit characters into the RX FIFO.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       RXD,
    input  logic       enable,
    input  logic [7:0] LCR,
    input  logic       rx_fifo_full,
    output logic [7:0] rx_data,
    output logic       rx_push,
    output logic       parity_error,
    output logic       framing_error,
    output logic       break_error,
    output logic       overrun_error,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_r, state_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxd_s, rxd_prev_r;
    logic [3:0]             tick_cnt_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shift_r;
    logic                   par_err_r;
    logic                   start_s, mid_start_s, sample_s, last_bit_s, stop_done_s;
    logic                   brk_s, hold_s;
    logic [7:0]             rx_data_r;
    logic                   rx_push_r, parity_error_r, framing_error_r, break_error_r;
    logic                   overrun_error_r, busy_r;
    logic                   unused_lcr_s;

    // LCR[5:4] selects odd / even / mark / space
    function automatic logic parity_expected(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'b00:   p = ~^data;
            2'b01:   p = ^data;
            2'b10:   p = 1'b1;
            2'b11:   p = 1'b0;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    assign rxd_s        = sync_r[SYNC_STAGES-1];
    assign sample_s     = enable && (tick_cnt_r == 4'd15);
    assign mid_start_s  = (state_r == START) && enable && (tick_cnt_r == 4'd7);
    assign last_bit_s   = (bit_idx_r == (3'd4 + {1'b0, LCR[1:0]}));
    assign start_s      = (state_r == IDLE) && rxd_prev_r && !rxd_s && !hold_s;
    assign stop_done_s  = (state_r == STOP) && sample_s;
    assign unused_lcr_s = ^{LCR[7:6], LCR[2]};

    // RXD synchroniser, idles high
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], RXD};
        end
    end

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = START;
                else         state_next_s = IDLE;
            end
            START: begin
                if (mid_start_s) state_next_s = rxd_s ? IDLE : DATA;
                else             state_next_s = START;
            end
            DATA: begin
                if (sample_s && last_bit_s) state_next_s = LCR[3] ? PARITY : STOP;
                else                        state_next_s = DATA;
            end
            PARITY: begin
                if (sample_s) state_next_s = STOP;
                else          state_next_s = PARITY;
            end
            STOP: begin
                if (sample_s) state_next_s = IDLE;
                else          state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Bit timing, deserialiser and parity check
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rxd_prev_r <= 1'b1;
            tick_cnt_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            par_err_r  <= 1'b0;
        end else begin
            rxd_prev_r <= rxd_s;
            // Re-phasing at mid start bit puts every later sample on a bit centre
            if (start_s || mid_start_s) tick_cnt_r <= 4'd0;
            else if (enable)            tick_cnt_r <= tick_cnt_r + 4'd1;
            if (start_s) begin
                shift_r   <= 8'd0;
                bit_idx_r <= 3'd0;
                par_err_r <= 1'b0;
            end else if ((state_r == DATA) && sample_s) begin
                shift_r[bit_idx_r] <= rxd_s;
                bit_idx_r          <= bit_idx_r + 3'd1;
            end else if ((state_r == PARITY) && sample_s) begin
                par_err_r <= (rxd_s != parity_expected(shift_r, LCR[5:4]));
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic       par_one_r, hold_r;
    logic [3:0] hold_cnt_r;

    assign brk_s  = (shift_r == 8'd0) && !par_one_r && !rxd_s;
    assign hold_s = hold_r;

    // After a break, start detection waits for 16 consecutive high ticks
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            par_one_r  <= 1'b0;
            hold_r     <= 1'b0;
            hold_cnt_r <= 4'd0;
        end else begin
            if (start_s)                             par_one_r <= 1'b0;
            else if ((state_r == PARITY) && sample_s) par_one_r <= rxd_s;
            if (stop_done_s && brk_s) begin
                hold_r     <= 1'b1;
                hold_cnt_r <= 4'd0;
            end else if (hold_r && enable) begin
                if (!rxd_s) begin
                    hold_cnt_r <= 4'd0;
                end else if (hold_cnt_r == 4'd15) begin
                    hold_r     <= 1'b0;
                    hold_cnt_r <= 4'd0;
                end else begin
                    hold_cnt_r <= hold_cnt_r + 4'd1;
                end
            end
        end
    end
`else
    assign brk_s  = 1'b0;
    assign hold_s = 1'b0;
`endif

    // Completion outputs; flags are only meaningful alongside the push
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_data_r       <= 8'd0;
            rx_push_r       <= 1'b0;
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
            break_error_r   <= 1'b0;
            overrun_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            if (stop_done_s) begin
                rx_data_r       <= shift_r;
                rx_push_r       <= !rx_fifo_full;
                overrun_error_r <= rx_fifo_full;
                parity_error_r  <= par_err_r;
                framing_error_r <= !rxd_s;
                break_error_r   <= brk_s;
            end else begin
                rx_push_r       <= 1'b0;
                overrun_error_r <= 1'b0;
                parity_error_r  <= 1'b0;
                framing_error_r <= 1'b0;
                break_error_r   <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_push       = rx_push_r;
    assign parity_error  = parity_error_r;
    assign framing_error = framing_error_r;
    assign break_error   = break_error_r;
    assign overrun_error = overrun_error_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: frames are serialised at 16 enables per bit and
// every captured push is compared against the expected {break, framing, parity, data}.
module tb_uart_rx_engine;
    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       RXD = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] LCR = 8'h03;
    logic       rx_fifo_full = 1'b0;
    logic [7:0] rx_data;
    logic       rx_push, parity_error, framing_error, break_error, overrun_error, busy;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];

    uart_rx_engine #(.SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .RXD(RXD), .enable(enable), .LCR(LCR),
        .rx_fifo_full(rx_fifo_full), .rx_data(rx_data), .rx_push(rx_push),
        .parity_error(parity_error), .framing_error(framing_error),
        .break_error(break_error), .overrun_error(overrun_error), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    // 16x baud tick: one PCLK high out of every four
    initial begin
        forever begin
            repeat (3) @(negedge PCLK);
            enable = 1'b1;
            @(negedge PCLK);
            enable = 1'b0;
        end
    end

    // Capture everything the DUT pushes
    always @(negedge PCLK) begin
        if (rx_push === 1'b1) obs_q.push_back({break_error, framing_error, parity_error, rx_data});
        if (overrun_error === 1'b1) ovr_cnt++;
    end

    task automatic wait_enables(input int n);
        repeat (n) begin
            @(posedge PCLK);
            while (enable !== 1'b1) @(posedge PCLK);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                              input logic par_val, input logic stop_val, input int gap);
        RXD = 1'b0;
        wait_enables(16);
        for (int i = 0; i < nbits; i++) begin
            RXD = data[i];
            wait_enables(16);
        end
        if (par_en) begin
            RXD = par_val;
            wait_enables(16);
        end
        RXD = stop_val;
        wait_enables(16);
        RXD = 1'b1;
        wait_enables(gap);
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (4) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({rx_data, rx_push, parity_error, framing_error, break_error, overrun_error, busy} !== 14'd0) begin
            errors++;
            $display("FAIL reset outputs got=%h want=0", {rx_data, rx_push, parity_error,
                     framing_error, break_error, overrun_error, busy});
        end
        PRESET = 1'b0;
        wait_enables(20);
    endtask

    task automatic test_8n1();
        logic [7:0] pats [3] = '{8'hA5, 8'h5A, 8'hFF};
        logic [10:0] e, o;
        LCR = 8'h03;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'b000, pats[i]});
            send_frame(pats[i], 8, 1'b0, 1'b0, 1'b1, 16);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL 8n1 no push, want=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL 8n1 got=%h want=%h", o, e); end
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] lcrs [6] = '{8'h1B, 8'h1B, 8'h0B, 8'h2B, 8'h3B, 8'h1B};
        logic [7:0] dats [6] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h07};
        logic       pbit [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       perr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [10:0] e, o;
        for (int i = 0; i < 6; i++) begin
            LCR = lcrs[i];
            exp_q.push_back({2'b00, perr[i], dats[i]});
            send_frame(dats[i], 8, 1'b1, pbit[i], 1'b1, 16);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL parity no push, want=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL parity got=%h want=%h", o, e); end
            end
        end
    endtask

    task automatic test_word_len();
        logic [10:0] e, o;
        LCR = 8'h00;
        exp_q.push_back({3'b000, 8'h15});
        send_frame(8'hF5, 5, 1'b0, 1'b0, 1'b1, 16);
        exp_q.push_back({3'b010, 8'h0A});
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b0, 16);
        LCR = 8'h01;
        exp_q.push_back({3'b000, 8'h2A});
        send_frame(8'hEA, 6, 1'b0, 1'b0, 1'b1, 16);
        LCR = 8'h02;
        exp_q.push_back({3'b000, 8'h5B});
        send_frame(8'hDB, 7, 1'b0, 1'b0, 1'b1, 16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL wordlen no push, want=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL wordlen got=%h want=%h", o, e); end
            end
        end
    endtask

    task automatic test_false_start();
        logic [10:0] o;
        LCR = 8'h03;
        RXD = 1'b0;
        wait_enables(2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_start got=%b want=1", busy); end
        wait_enables(2);
        RXD = 1'b1;
        wait_enables(32);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL false_start pushes=%0d busy=%b want 0/0", obs_q.size(), busy);
        end
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 16);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL after_false_start pushes=%0d want=1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o !== {3'b000, 8'h55}) begin errors++; $display("FAIL after_false_start got=%h want=055", o); end
        end
    endtask

    task automatic test_overrun_and_reset();
        LCR = 8'h03;
        ovr_cnt = 0;
        rx_fifo_full = 1'b1;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 16);
        rx_fifo_full = 1'b0;
        checks++;
        if (obs_q.size() != 0 || ovr_cnt != 1) begin
            errors++;
            $display("FAIL overrun pushes=%0d pulses=%0d want 0/1", obs_q.size(), ovr_cnt);
        end
        RXD = 1'b0;
        wait_enables(16 * 3 + 4);
        RXD = 1'b1;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({rx_data, rx_push, busy} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=0", {rx_data, rx_push, busy});
        end
        PRESET = 1'b0;
        wait_enables(16 * 8);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_push pushes=%0d busy=%b want 0/0", obs_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [3] = '{8'h12, 8'h34, 8'hC3};
        logic [10:0] e, o;
        LCR = 8'h03;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'b000, pats[i]});
            send_frame(pats[i], 8, 1'b0, 1'b0, 1'b1, (i == 2) ? 16 : 0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL b2b no push, want=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b got=%h want=%h", o, e); end
            end
        end
    endtask

    task automatic test_break();
        logic [10:0] e, o;
        LCR = 8'h03;
`ifdef UART_RX_BREAK_DETECT_EN
        exp_q.push_back({3'b110, 8'h00});
        RXD = 1'b0;
        wait_enables(16 * 12);
        RXD = 1'b1;
        wait_enables(8);
        RXD = 1'b0;
        wait_enables(16);
        RXD = 1'b1;
        wait_enables(40);
        exp_q.push_back({3'b000, 8'h99});
        send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1, 16);
`else
        exp_q.push_back({3'b010, 8'h00});
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 16);
        exp_q.push_back({3'b000, 8'h99});
        send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1, 16);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL break no push, want=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL break got=%h want=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL break extra pushes=%0d want=0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_word_len();
        test_false_start();
        test_overrun_and_reset();
        test_back_to_back();
        test_break();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
